// File: rtl/attn_pkg.sv
// Shared types for the attention-engine phase sequencer.
// Holds the FSM state and phase encodings plus operand-select codes.
package attn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_ADDR,
      ST_HDR_DATA,
      ST_CALC,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } e_seq_state;

   typedef enum logic [2:0] {
      PH_Q    = 3'd0,
      PH_K    = 3'd1,
      PH_V    = 3'd2,
      PH_S    = 3'd3,
      PH_Z    = 3'd4,
      PH_NONE = 3'd7
   } e_phase;

   // A-operand sources
   localparam logic [1:0] SRC_INPUT   = 2'd0;
   localparam logic [1:0] SRC_RESULT  = 2'd1;
   // B-operand sources
   localparam logic [1:0] SRC_WEIGHT  = 2'd0;
   localparam logic [1:0] SRC_SCRATCH = 2'd1;

endpackage

// File: rtl/attn_addr_calc.sv
// Combinational phase configuration: operand selects, bases, dims, placement.
// In: N, D, ND, NN, DD, phase. Out: full engine configuration for that phase.
module attn_addr_calc
   import attn_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 16
) (
   input  logic [DIM_W-1:0]  i_n,
   input  logic [DIM_W-1:0]  i_d,
   input  logic [ADDR_W-1:0] i_nd,
   input  logic [ADDR_W-1:0] i_nn,
   input  logic [ADDR_W-1:0] i_dd,
   input  e_phase            i_phase,
   output logic [1:0]        o_a_sel,
   output logic [1:0]        o_b_sel,
   output logic              o_b_transpose,
   output logic [ADDR_W-1:0] o_a_base,
   output logic [ADDR_W-1:0] o_b_base,
   output logic [DIM_W-1:0]  o_rows,
   output logic [DIM_W-1:0]  o_inner,
   output logic [DIM_W-1:0]  o_cols,
   output logic [ADDR_W-1:0] o_out_base,
   output logic              o_mirror_en,
   output logic [ADDR_W-1:0] o_mirror_base
);

   localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

   // Result SRAM holds Q, K, V back to back, then S, then Z.
   logic [ADDR_W-1:0] w_nd2;
   logic [ADDR_W-1:0] w_nd3;

   assign w_nd2 = i_nd << 1;
   assign w_nd3 = w_nd2 + i_nd;

   always_comb begin
      o_a_sel       = SRC_INPUT;
      o_b_sel       = SRC_WEIGHT;
      o_b_transpose = 1'b0;
      o_a_base      = '0;
      o_b_base      = '0;
      o_rows        = '0;
      o_inner       = '0;
      o_cols        = '0;
      o_out_base    = '0;
      o_mirror_en   = 1'b0;
      o_mirror_base = '0;
      case (i_phase)
         PH_Q: begin
            o_a_base = ONE;
            o_b_base = ONE;
            o_rows   = i_n;
            o_inner  = i_d;
            o_cols   = i_d;
         end
         PH_K: begin
            o_a_base    = ONE;
            o_b_base    = ONE + i_dd;
            o_rows      = i_n;
            o_inner     = i_d;
            o_cols      = i_d;
            o_out_base  = i_nd;
            o_mirror_en = 1'b1;
         end
         PH_V: begin
            o_a_base      = ONE;
            o_b_base      = ONE + (i_dd << 1);
            o_rows        = i_n;
            o_inner       = i_d;
            o_cols        = i_d;
            o_out_base    = w_nd2;
            o_mirror_en   = 1'b1;
            o_mirror_base = i_nd;
         end
         PH_S: begin
            // Q from result@0, K^T from its scratch mirror
            o_a_sel       = SRC_RESULT;
            o_b_sel       = SRC_SCRATCH;
            o_b_transpose = 1'b1;
            o_rows        = i_n;
            o_inner       = i_d;
            o_cols        = i_n;
            o_out_base    = w_nd3;
         end
         PH_Z: begin
            // S from result, V from its scratch mirror
            o_a_sel    = SRC_RESULT;
            o_a_base   = w_nd3;
            o_b_sel    = SRC_SCRATCH;
            o_b_base   = i_nd;
            o_rows     = i_n;
            o_inner    = i_n;
            o_cols     = i_d;
            o_out_base = w_nd3 + i_nn;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/attn_phase_sequencer.sv
// Self-attention scheduler: job handshake, header fetch, Q/K/V/S/Z issue.
// Ports: dut_valid/ready job, hdr_* header read, eng_* engine config/start/done.
module attn_phase_sequencer
   import attn_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int DIM_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dut_valid,
   output logic              dut_ready,
   output logic              hdr_owns_port,
   output logic [ADDR_W-1:0] hdr_input_rd_addr,
   output logic [ADDR_W-1:0] hdr_weight_rd_addr,
   input  logic [DATA_W-1:0] tb__dut__sram_input_read_data,
   input  logic [DATA_W-1:0] tb__dut__sram_weight_read_data,
   output logic              eng_start,
   output logic [1:0]        eng_a_sel,
   output logic [1:0]        eng_b_sel,
   output logic              eng_b_transpose,
   output logic [ADDR_W-1:0] eng_a_base,
   output logic [ADDR_W-1:0] eng_b_base,
   output logic [DIM_W-1:0]  eng_rows,
   output logic [DIM_W-1:0]  eng_inner,
   output logic [DIM_W-1:0]  eng_cols,
   output logic [ADDR_W-1:0] eng_out_base,
   output logic              eng_mirror_en,
   output logic [ADDR_W-1:0] eng_mirror_base,
   input  logic              eng_done,
   output logic [2:0]        phase_id,
   output logic              cfg_err
);

   e_seq_state        r_state;
   e_phase            r_phase_id;
   logic              r_ready;
   logic              r_start;
   logic              r_cfg_err;
   logic [DIM_W-1:0]  r_n;
   logic [DIM_W-1:0]  r_d;
   logic              r_w_zero;
   logic [ADDR_W-1:0] r_nd;
   logic [ADDR_W-1:0] r_nn;
   logic [ADDR_W-1:0] r_dd;

   logic [1:0]        r_a_sel;
   logic [1:0]        r_b_sel;
   logic              r_b_tr;
   logic [ADDR_W-1:0] r_a_base;
   logic [ADDR_W-1:0] r_b_base;
   logic [DIM_W-1:0]  r_rows;
   logic [DIM_W-1:0]  r_inner;
   logic [DIM_W-1:0]  r_cols;
   logic [ADDR_W-1:0] r_out_base;
   logic              r_mir_en;
   logic [ADDR_W-1:0] r_mir_base;

   logic [1:0]        w_a_sel;
   logic [1:0]        w_b_sel;
   logic              w_b_tr;
   logic [ADDR_W-1:0] w_a_base;
   logic [ADDR_W-1:0] w_b_base;
   logic [DIM_W-1:0]  w_rows;
   logic [DIM_W-1:0]  w_inner;
   logic [DIM_W-1:0]  w_cols;
   logic [ADDR_W-1:0] w_out_base;
   logic              w_mir_en;
   logic [ADDR_W-1:0] w_mir_base;

   e_phase            w_next_phase;
   logic              w_zero;
   logic              w_load;
   logic [ADDR_W-1:0] w_n_a;
   logic [ADDR_W-1:0] w_d_a;

   // Products are taken at address width so they wrap modulo 2^ADDR_W.
   assign w_n_a = ADDR_W'(r_n);
   assign w_d_a = ADDR_W'(r_d);

   // The weight header carries D twice; a zero there is also a zero dim.
   assign w_zero = (r_n == '0) || (r_d == '0) || r_w_zero;

   assign w_next_phase = (r_state == ST_WAIT) ?
                         e_phase'(r_phase_id + 3'd1) : PH_Q;

   assign w_load = ((r_state == ST_CALC) && !w_zero) ||
                   ((r_state == ST_WAIT) && eng_done &&
                    (r_phase_id != PH_Z));

   attn_addr_calc #(
      .ADDR_W (ADDR_W),
      .DIM_W  (DIM_W)
   ) u_calc (
      .i_n           (r_n),
      .i_d           (r_d),
      .i_nd          (r_nd),
      .i_nn          (r_nn),
      .i_dd          (r_dd),
      .i_phase       (w_next_phase),
      .o_a_sel       (w_a_sel),
      .o_b_sel       (w_b_sel),
      .o_b_transpose (w_b_tr),
      .o_a_base      (w_a_base),
      .o_b_base      (w_b_base),
      .o_rows        (w_rows),
      .o_inner       (w_inner),
      .o_cols        (w_cols),
      .o_out_base    (w_out_base),
      .o_mirror_en   (w_mir_en),
      .o_mirror_base (w_mir_base)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_phase_id <= PH_NONE;
         r_ready    <= 1'b0;
         r_start    <= 1'b0;
         r_cfg_err  <= 1'b0;
         r_n        <= '0;
         r_d        <= '0;
         r_w_zero   <= 1'b0;
         r_nd       <= '0;
         r_nn       <= '0;
         r_dd       <= '0;
      end else begin
         r_start <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (dut_valid) begin
                  r_ready   <= 1'b0;
                  r_cfg_err <= 1'b0;
                  r_state   <= ST_HDR_ADDR;
               end else begin
                  r_ready <= 1'b1;
               end
            end
            ST_HDR_ADDR: r_state <= ST_HDR_DATA;
            ST_HDR_DATA: begin
               r_n <= tb__dut__sram_input_read_data[2*DIM_W-1:DIM_W];
               r_d <= tb__dut__sram_input_read_data[DIM_W-1:0];
               r_w_zero <=
                  (tb__dut__sram_weight_read_data[2*DIM_W-1:DIM_W] == '0) ||
                  (tb__dut__sram_weight_read_data[DIM_W-1:0] == '0);
               r_state <= ST_CALC;
            end
            ST_CALC: begin
               r_nd <= w_n_a * w_d_a;
               r_nn <= w_n_a * w_n_a;
               r_dd <= w_d_a * w_d_a;
               if (w_zero) begin
                  r_cfg_err  <= 1'b1;
                  r_phase_id <= PH_NONE;
                  r_state    <= ST_DONE;
               end else begin
                  r_start    <= 1'b1;
                  r_phase_id <= w_next_phase;
                  r_state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: r_state <= ST_WAIT;
            ST_WAIT: begin
               if (eng_done) begin
                  if (r_phase_id == PH_Z) begin
                     r_phase_id <= PH_NONE;
                     r_state    <= ST_DONE;
                  end else begin
                     r_start    <= 1'b1;
                     r_phase_id <= w_next_phase;
                     r_state    <= ST_ISSUE;
                  end
               end
            end
            ST_DONE: begin
               r_ready <= 1'b1;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a_sel    <= '0;
         r_b_sel    <= '0;
         r_b_tr     <= 1'b0;
         r_a_base   <= '0;
         r_b_base   <= '0;
         r_rows     <= '0;
         r_inner    <= '0;
         r_cols     <= '0;
         r_out_base <= '0;
         r_mir_en   <= 1'b0;
         r_mir_base <= '0;
      end else if (w_load) begin
         r_a_sel    <= w_a_sel;
         r_b_sel    <= w_b_sel;
         r_b_tr     <= w_b_tr;
         r_a_base   <= w_a_base;
         r_b_base   <= w_b_base;
         r_rows     <= w_rows;
         r_inner    <= w_inner;
         r_cols     <= w_cols;
         r_out_base <= w_out_base;
         r_mir_en   <= w_mir_en;
         r_mir_base <= w_mir_base;
      end
   end

   assign dut_ready          = r_ready;
   assign hdr_owns_port      = (r_state == ST_HDR_ADDR) ||
                               (r_state == ST_HDR_DATA);
   assign hdr_input_rd_addr  = '0;
   assign hdr_weight_rd_addr = '0;
   assign eng_start          = r_start;
   assign eng_a_sel          = r_a_sel;
   assign eng_b_sel          = r_b_sel;
   assign eng_b_transpose    = r_b_tr;
   assign eng_a_base         = r_a_base;
   assign eng_b_base         = r_b_base;
   assign eng_rows           = r_rows;
   assign eng_inner          = r_inner;
   assign eng_cols           = r_cols;
   assign eng_out_base       = r_out_base;
   assign eng_mirror_en      = r_mir_en;
   assign eng_mirror_base    = r_mir_base;
   assign phase_id           = r_phase_id;
   assign cfg_err            = r_cfg_err;

endmodule

// File: tb/tb_attn_phase_sequencer.sv
// Self-checking bench for attn_phase_sequencer.
// Table vectors, hand-written corner sequences and random jobs vs a model.
module tb_attn_phase_sequencer;

   typedef struct packed {
      logic [1:0]  a_sel;
      logic [15:0] a_base;
      logic [1:0]  b_sel;
      logic [15:0] b_base;
      logic        tr;
      logic [15:0] rows;
      logic [15:0] inner;
      logic [15:0] cols;
      logic [15:0] ob;
      logic        me;
      logic [15:0] mb;
   } cfg_t;

   typedef struct {
      logic [15:0] n;
      logic [15:0] d;
      int          ph;
      cfg_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        dut_valid = 1'b0;
   logic        eng_done = 1'b0;
   logic [31:0] in_hdr = '0;
   logic [31:0] w_hdr = '0;
   logic [31:0] in_rd = '0;
   logic [31:0] w_rd = '0;

   logic        dut_ready;
   logic        hdr_owns_port;
   logic [15:0] hdr_input_rd_addr;
   logic [15:0] hdr_weight_rd_addr;
   logic        eng_start;
   logic [1:0]  eng_a_sel;
   logic [1:0]  eng_b_sel;
   logic        eng_b_transpose;
   logic [15:0] eng_a_base;
   logic [15:0] eng_b_base;
   logic [15:0] eng_rows;
   logic [15:0] eng_inner;
   logic [15:0] eng_cols;
   logic [15:0] eng_out_base;
   logic        eng_mirror_en;
   logic [15:0] eng_mirror_base;
   logic [2:0]  phase_id;
   logic        cfg_err;

   int   checks = 0;
   int   passes = 0;
   cfg_t obs [5];
   vec_t tbl [10];

   attn_phase_sequencer dut (
      .clk                            (clk),
      .reset                          (reset),
      .dut_valid                      (dut_valid),
      .dut_ready                      (dut_ready),
      .hdr_owns_port                  (hdr_owns_port),
      .hdr_input_rd_addr              (hdr_input_rd_addr),
      .hdr_weight_rd_addr             (hdr_weight_rd_addr),
      .tb__dut__sram_input_read_data  (in_rd),
      .tb__dut__sram_weight_read_data (w_rd),
      .eng_start                      (eng_start),
      .eng_a_sel                      (eng_a_sel),
      .eng_b_sel                      (eng_b_sel),
      .eng_b_transpose                (eng_b_transpose),
      .eng_a_base                     (eng_a_base),
      .eng_b_base                     (eng_b_base),
      .eng_rows                       (eng_rows),
      .eng_inner                      (eng_inner),
      .eng_cols                       (eng_cols),
      .eng_out_base                   (eng_out_base),
      .eng_mirror_en                  (eng_mirror_en),
      .eng_mirror_base                (eng_mirror_base),
      .eng_done                       (eng_done),
      .phase_id                       (phase_id),
      .cfg_err                        (cfg_err)
   );

   always #5 clk = ~clk;

   // Header SRAMs: one-cycle read latency, only address 0 is populated.
   always @(posedge clk) begin
      in_rd <= in_hdr;
      w_rd  <= w_hdr;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   function automatic cfg_t mk(int as_, int ab, int bs, int bb, int tr,
                               int r, int i, int c, int ob, int me, int mb);
      cfg_t x;
      x.a_sel  = 2'(as_);
      x.a_base = 16'(ab);
      x.b_sel  = 2'(bs);
      x.b_base = 16'(bb);
      x.tr     = 1'(tr);
      x.rows   = 16'(r);
      x.inner  = 16'(i);
      x.cols   = 16'(c);
      x.ob     = 16'(ob);
      x.me     = 1'(me);
      x.mb     = 16'(mb);
      return x;
   endfunction

   function automatic cfg_t cap();
      cfg_t c;
      c.a_sel  = eng_a_sel;
      c.a_base = eng_a_base;
      c.b_sel  = eng_b_sel;
      c.b_base = eng_b_base;
      c.tr     = eng_b_transpose;
      c.rows   = eng_rows;
      c.inner  = eng_inner;
      c.cols   = eng_cols;
      c.ob     = eng_out_base;
      c.me     = eng_mirror_en;
      c.mb     = eng_mirror_en ? eng_mirror_base : 16'h0;
      return c;
   endfunction

   // Reference: outputs are laid out back to back as Q,K,V (N x D each),
   // S (N x N), Z; K and V are mirrored into scratch at 0 and ND.
   function automatic cfg_t model(input logic [15:0] n,
                                  input logic [15:0] d, input int p);
      cfg_t c;
      int   sz   [5];
      int   outb [5];
      int   mir  [3];
      int   nd, nn, dd;
      nd = int'(n) * int'(d);
      nn = int'(n) * int'(n);
      dd = int'(d) * int'(d);
      sz = '{nd, nd, nd, nn, nd};
      outb[0] = 0;
      for (int k = 1; k < 5; k++) outb[k] = outb[k-1] + sz[k-1];
      mir = '{0, 0, nd};
      c = '0;
      c.rows = n;
      c.ob   = 16'(outb[p]);
      if (p < 3) begin
         c.a_base = 16'd1;
         c.b_base = 16'(1 + p * dd);
         c.inner  = d;
         c.cols   = d;
         if (p > 0) begin
            c.me = 1'b1;
            c.mb = 16'(mir[p]);
         end
      end else if (p == 3) begin
         c.a_sel  = 2'd1;
         c.a_base = 16'(outb[0]);
         c.b_sel  = 2'd1;
         c.b_base = 16'(mir[1]);
         c.tr     = 1'b1;
         c.inner  = d;
         c.cols   = n;
      end else begin
         c.a_sel  = 2'd1;
         c.a_base = 16'(outb[3]);
         c.b_sel  = 2'd1;
         c.b_base = 16'(mir[2]);
         c.inner  = n;
         c.cols   = d;
      end
      return c;
   endfunction

   task automatic run_job(input logic [15:0] n, input logic [15:0] d,
                          input int max_lat, input bit spur,
                          input int abort_p, input bit hold);
      int   cnt;
      bit   seen;
      cfg_t e;
      in_hdr = {n, d};
      w_hdr  = {d, d};
      cnt = 0;
      while (dut_ready !== 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("ready_before_job", 128'(dut_ready), 128'(1));
      dut_valid = 1'b1;
      tick();
      if (!hold) dut_valid = 1'b0;
      chk("accept", {dut_ready, hdr_owns_port, cfg_err,
                     hdr_input_rd_addr, hdr_weight_rd_addr},
          {1'b0, 1'b1, 1'b0, 16'h0, 16'h0});
      if (n == 16'h0 || d == 16'h0) begin
         cnt  = 0;
         seen = 1'b0;
         while (dut_ready !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
            if (eng_start) seen = 1'b1;
         end
         chk("zero_dim", {seen, cfg_err, phase_id, 8'(cnt)},
             {1'b0, 1'b1, 3'd7, 8'd4});
         return;
      end
      for (int p = 0; p < 5; p++) begin
         cnt = 0;
         while (eng_start !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
         end
         chk($sformatf("start_lat_p%0d", p), 128'(cnt),
             128'(p == 0 ? 3 : 0));
         e = model(n, d, p);
         obs[p] = cap();
         chk($sformatf("cfg_n%0d_d%0d_p%0d", n, d, p), obs[p], e);
         chk($sformatf("phase_id_p%0d", p), 128'(phase_id), 128'(p));
         if (spur) eng_done = 1'b1;
         tick();
         eng_done = 1'b0;
         chk($sformatf("start_pulse_p%0d", p), {eng_start, phase_id},
             {1'b0, 3'(p)});
         if (p == abort_p) begin
            #2 reset = 1'b1;
            #1;
            chk("async_reset", {dut_ready, eng_start, hdr_owns_port,
                                phase_id, cfg_err, cap()},
                {1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 118'h0});
            #1 reset = 1'b0;
            tick();
            chk("ready_after_abort", {dut_ready, phase_id},
                {1'b1, 3'd7});
            return;
         end
         repeat ($urandom_range(max_lat, 0)) tick();
         chk($sformatf("cfg_held_p%0d", p), cap(), e);
         eng_done = 1'b1;
         tick();
         eng_done = 1'b0;
      end
      chk("done_state", {dut_ready, phase_id, eng_start},
          {1'b0, 3'd7, 1'b0});
      tick();
      chk("ready_2_after_done", 128'(dut_ready), 128'(1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] rn, rd;

      tbl[0] = '{16'd4, 16'd4, 0, mk(0, 1, 0, 1, 0, 4, 4, 4, 0, 0, 0)};
      tbl[1] = '{16'd4, 16'd4, 1, mk(0, 1, 0, 17, 0, 4, 4, 4, 16, 1, 0)};
      tbl[2] = '{16'd4, 16'd4, 2, mk(0, 1, 0, 33, 0, 4, 4, 4, 32, 1, 16)};
      tbl[3] = '{16'd4, 16'd4, 3, mk(1, 0, 1, 0, 1, 4, 4, 4, 48, 0, 0)};
      tbl[4] = '{16'd4, 16'd4, 4, mk(1, 48, 1, 16, 0, 4, 4, 4, 64, 0, 0)};
      tbl[5] = '{16'd3, 16'd5, 0, mk(0, 1, 0, 1, 0, 3, 5, 5, 0, 0, 0)};
      tbl[6] = '{16'd3, 16'd5, 1, mk(0, 1, 0, 26, 0, 3, 5, 5, 15, 1, 0)};
      tbl[7] = '{16'd3, 16'd5, 2, mk(0, 1, 0, 51, 0, 3, 5, 5, 30, 1, 15)};
      tbl[8] = '{16'd3, 16'd5, 3, mk(1, 0, 1, 0, 1, 3, 5, 3, 45, 0, 0)};
      tbl[9] = '{16'd3, 16'd5, 4, mk(1, 45, 1, 15, 0, 3, 3, 5, 54, 0, 0)};

      // Reset values while reset is held
      #12;
      chk("reset_values", {dut_ready, eng_start, hdr_owns_port,
                           phase_id, cfg_err, cap()},
          {1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 118'h0});
      reset = 1'b0;
      tick();
      chk("ready_after_reset", 128'(dut_ready), 128'(1));

      // Spurious done while idle
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      chk("spur_done_idle", {dut_ready, phase_id, eng_start, hdr_owns_port},
          {1'b1, 3'd7, 1'b0, 1'b0});
      tick();
      chk("still_idle", {dut_ready, eng_start}, {1'b1, 1'b0});

      // Table vectors; the N=4 job also injects done during each ISSUE
      for (int j = 0; j < 10; j++) begin
         if (j % 5 == 0) run_job(tbl[j].n, tbl[j].d, 2, j == 0, -1, 1'b0);
         chk($sformatf("tbl_%0d", j), obs[tbl[j].ph], tbl[j].exp);
      end

      // Zero dimension header
      run_job(16'd0, 16'd4, 0, 1'b0, -1, 1'b0);
      // A clean job after an error clears cfg_err
      run_job(16'd2, 16'd2, 1, 1'b0, -1, 1'b0);
      chk("err_cleared", 128'(cfg_err), 128'(0));

      // Reset during WAIT of V, then restart from Q
      run_job(16'd6, 16'd2, 2, 1'b0, 2, 1'b0);
      run_job(16'd6, 16'd2, 1, 1'b0, -1, 1'b0);

      // Back-to-back with dut_valid held high and a new header
      run_job(16'd2, 16'd7, 1, 1'b0, -1, 1'b1);
      run_job(16'd5, 16'd3, 2, 1'b0, -1, 1'b0);

      // Random jobs, including large dims that wrap the address space
      for (int r = 0; r < 12; r++) begin
         rn = 16'($urandom_range(300, 1));
         rd = ($urandom_range(7, 0) == 0) ? 16'h0 :
              16'($urandom_range(300, 1));
         run_job(rn, rd, 3, 1'($urandom_range(1, 0)), -1, 1'b0);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/attn_phase_sequencer.md
Name: attn_phase_sequencer

Overview:
Top-level scheduler for the self-attention engine. Accepts the dut_valid/dut_ready job handshake and fetches the input and weight dimension headers. It then sequences one shared matrix-multiply datapath through five phases: Q, K, V, S = Q*K^T, Z = S*V. For each phase it drives operand select, base addresses, dimensions and output placement, then waits for the engine's done pulse before issuing the next phase.

Parameters:
ADDR_W, 16, SRAM address width; all address arithmetic is modulo 2^ADDR_W.
DATA_W, 32, SRAM data width; header word is {rows[31:16], cols[15:0]}.
DIM_W, 16, width of each dimension field.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
dut_valid  in  1  job request from the testbench.
dut_ready  out  1  high when idle and able to accept a job.
hdr_owns_port  out  1  high while the sequencer drives the input and weight SRAM read addresses.
hdr_input_rd_addr  out  ADDR_W  input SRAM read address; always 0.
hdr_weight_rd_addr  out  ADDR_W  weight SRAM read address; always 0.
tb__dut__sram_input_read_data  in  DATA_W  input header word {N, D}.
tb__dut__sram_weight_read_data  in  DATA_W  weight header word {D, D}.
eng_start  out  1  one-cycle pulse; all eng_* configuration outputs are valid and held stable until eng_done.
eng_a_sel  out  2  A-operand source: 0=input SRAM, 1=result SRAM.
eng_b_sel  out  2  B-operand source: 0=weight SRAM, 1=scratchpad SRAM.
eng_b_transpose  out  1  B is read column-major.
eng_a_base  out  ADDR_W  A-operand base address.
eng_b_base  out  ADDR_W  B-operand base address.
eng_rows  out  DIM_W  output rows.
eng_inner  out  DIM_W  inner (reduction) dimension.
eng_cols  out  DIM_W  output columns.
eng_out_base  out  ADDR_W  result SRAM write base.
eng_mirror_en  out  1  also write each output element to scratchpad.
eng_mirror_base  out  ADDR_W  scratchpad write base.
eng_done  in  1  one-cycle pulse from the engine; the current phase is complete.
phase_id  out  3  current phase: 0=Q, 1=K, 2=V, 3=S, 4=Z, 7=none.
cfg_err  out  1  sticky per job; set on a zero dimension.

Behaviour:
- Reset values: dut_ready=0, eng_start=0, hdr_owns_port=0, all eng_* outputs=0, phase_id=7, cfg_err=0, state=IDLE.
- State machine: IDLE -> HDR_ADDR -> HDR_DATA -> CALC -> ISSUE -> WAIT -> (ISSUE for the next phase | DONE) -> IDLE.
- IDLE:
  - dut_ready is a register, =1 from the cycle after entering IDLE.
  - dut_valid=1 in IDLE: accept the job. dut_ready=0 the next cycle; cfg_err clears.
- HDR_ADDR: hdr_owns_port=1; both SRAM read addresses are 0. SRAM read latency is 1 cycle.
- HDR_DATA: latch N=input[31:16], D=input[15:0]. hdr_owns_port stays 1.
- CALC: register ND=N*D, NN=N*N, DD=D*D, each truncated to ADDR_W. If N==0 or D==0: set cfg_err and go to DONE.
- Phase table (A, B, rows/inner/cols, out, mirror):
  - Q: input@1, weight@1, N/D/D, out 0, no mirror.
  - K: input@1, weight@1+DD, N/D/D, out ND, mirror@0.
  - V: input@1, weight@1+2DD, N/D/D, out 2ND, mirror@ND.
  - S: result@0, scratch@0 with transpose, N/D/N, out 3ND, no mirror.
  - Z: result@3ND, scratch@ND, N/N/D, out 3ND+NN, no mirror.
- ISSUE: drive the phase's configuration and pulse eng_start for exactly 1 cycle; phase_id is updated in the same cycle.
- WAIT:
  - Hold configuration and phase_id.
  - eng_done -> if phase < Z, go to ISSUE for phase+1 (the next eng_start comes 1 cycle after done); otherwise go to DONE.
  - Minimum gap from done to the next start is 1 cycle.
- DONE: phase_id=7; go to IDLE. dut_ready=1 two cycles after the final eng_done.
- eng_done outside WAIT is ignored. dut_valid outside IDLE is ignored; dut_valid held high after completion starts a new job.
- Reset mid-job: immediate return to IDLE. eng_start deasserts asynchronously; the partial job is abandoned.

Decomposition:
- Package attn_pkg:
  - e_seq_state enum, 3-bit.
  - e_phase enum: Q=0, K=1, V=2, S=3, Z=4, NONE=7.
  - Operand-select constants SRC_INPUT, SRC_RESULT, SRC_WEIGHT, SRC_SCRATCH.
- Sub-module attn_addr_calc (combinational): from N, D, ND, NN, DD and phase, produce the full eng_* configuration word. The FSM only registers its output in ISSUE.

Test Plan:
- N=4, D=4: after the header, 5 eng_start pulses. out_base values 0, 16, 32, 48, 64; weight bases 1, 17, 33; mirror bases 0, 16; dut_ready=1 2 cycles after the 5th done.
- N=3, D=5: S is issued with rows 3, inner 5, cols 3, transpose=1. Z is issued with a_base 45, inner 3, cols 5, out_base 54.
- Header {0, 4}: cfg_err=1, no eng_start, dut_ready returns in 4 cycles.
- Spurious eng_done in IDLE and ISSUE: phase_id and state are unchanged; no extra phase is issued.
- Reset asserted during WAIT of phase V: outputs return to reset values the same cycle. The next dut_valid restarts at Q.
- Back-to-back jobs with dut_valid held high and different headers: the second job uses the new N and D; no configuration carries over.
